// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags.
// Commit writes values, dispatch renames destinations, flush drops all pending tags.
module reg_file_rename #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned TAG_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       commit_valid,
    input  logic [$clog2(REG_NUM)-1:0] commit_rd,
    input  logic [XLEN-1:0]            commit_res,
    input  logic [TAG_W-1:0]           commit_dependency,
    input  logic                       rename_valid,
    input  logic [$clog2(REG_NUM)-1:0] rename_rd,
    input  logic [TAG_W-1:0]           rename_tag,
    input  logic [$clog2(REG_NUM)-1:0] rs1_addr,
    input  logic [$clog2(REG_NUM)-1:0] rs2_addr,
    output logic                       rs1_busy,
    output logic [TAG_W-1:0]           rs1_tag,
    output logic [XLEN-1:0]            rs1_value,
    output logic                       rs2_busy,
    output logic [TAG_W-1:0]           rs2_tag,
    output logic [XLEN-1:0]            rs2_value
);

    localparam int unsigned AW = $clog2(REG_NUM);

    logic [XLEN-1:0]    value_q [REG_NUM];
    logic [XLEN-1:0]    value_d [REG_NUM];
    logic [TAG_W-1:0]   tag_q   [REG_NUM];
    logic [TAG_W-1:0]   tag_d   [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    logic               commit_en;
    logic               rename_en;

    assign commit_en = commit_valid && (commit_rd != '0);
    assign rename_en = rename_valid && (rename_rd != '0) && !flush;

    // Next state: commit first, then rename/flush override busy and tag.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (commit_en) begin
            value_d[commit_rd] = commit_res;
            if (tag_q[commit_rd] == commit_dependency) begin
                busy_d[commit_rd] = 1'b0;
                tag_d[commit_rd]  = '0;
            end
        end
        if (flush) begin
            busy_d = '0;
            for (int i = 0; i < int'(REG_NUM); i++) begin
                tag_d[i] = '0;
            end
        end else if (rename_en) begin
            busy_d[rename_rd] = 1'b1;
            tag_d[rename_rd]  = rename_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < int'(REG_NUM); i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy) begin
            busy_q  <= busy_d;
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    // Read ports with commit bypass; a same-cycle rename is deliberately not visible.
    logic [AW-1:0]    rd_addr  [2];
    logic             rd_busy  [2];
    logic [TAG_W-1:0] rd_tag   [2];
    logic [XLEN-1:0]  rd_value [2];

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_busy[p]  = 1'b0;
            rd_tag[p]   = '0;
            rd_value[p] = '0;
            if (rd_addr[p] != '0) begin
                if (commit_valid && (commit_rd == rd_addr[p]) && busy_q[rd_addr[p]]
                    && (tag_q[rd_addr[p]] == commit_dependency)) begin
                    rd_value[p] = commit_res;
                end else begin
                    rd_busy[p]  = busy_q[rd_addr[p]];
                    rd_tag[p]   = busy_q[rd_addr[p]] ? tag_q[rd_addr[p]] : '0;
                    rd_value[p] = value_q[rd_addr[p]];
                end
            end
        end
    end

    assign rs1_busy  = rd_busy[0];
    assign rs1_tag   = rd_tag[0];
    assign rs1_value = rd_value[0];
    assign rs2_busy  = rd_busy[1];
    assign rs2_tag   = rd_tag[1];
    assign rs2_value = rd_value[1];

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename: rename, commit, bypass, flush, stall and reset.
module tb_reg_file_rename;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_res;
    logic [4:0]  commit_dependency;
    logic        rename_valid;
    logic [4:0]  rename_rd;
    logic [4:0]  rename_tag;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic [4:0]  rs1_tag;
    logic [31:0] rs1_value;
    logic        rs2_busy;
    logic [4:0]  rs2_tag;
    logic [31:0] rs2_value;

    int checks = 0;
    int errors = 0;

    reg_file_rename #(.XLEN(32), .REG_NUM(32), .TAG_W(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .flush             (flush),
        .commit_valid      (commit_valid),
        .commit_rd         (commit_rd),
        .commit_res        (commit_res),
        .commit_dependency (commit_dependency),
        .rename_valid      (rename_valid),
        .rename_rd         (rename_rd),
        .rename_tag        (rename_tag),
        .rs1_addr          (rs1_addr),
        .rs2_addr          (rs2_addr),
        .rs1_busy          (rs1_busy),
        .rs1_tag           (rs1_tag),
        .rs1_value         (rs1_value),
        .rs2_busy          (rs2_busy),
        .rs2_tag           (rs2_tag),
        .rs2_value         (rs2_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        flush        = 1'b0;
        commit_valid = 1'b0;
        commit_rd    = 5'd0;
        commit_res   = 32'd0;
        commit_dependency = 5'd0;
        rename_valid = 1'b0;
        rename_rd    = 5'd0;
        rename_tag   = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [4:0] dep, input logic [31:0] res);
        commit_valid = 1'b1;
        commit_rd = rd;
        commit_dependency = dep;
        commit_res = res;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [4:0] tag);
        rename_valid = 1'b1;
        rename_rd = rd;
        rename_tag = tag;
    endtask

    task automatic rd1(input string name, input logic [4:0] a,
                       input logic eb, input logic [4:0] et, input logic [31:0] ev);
        rs1_addr = a;
        #1;
        checks++;
        assert ({rs1_busy, rs1_tag, rs1_value} === {eb, et, ev})
        else begin
            errors++;
            $error("FAIL %s: rs1 x%0d got busy=%b tag=%0d value=%h, expected busy=%b tag=%0d value=%h",
                   name, a, rs1_busy, rs1_tag, rs1_value, eb, et, ev);
        end
    endtask

    task automatic rd2(input string name, input logic [4:0] a,
                       input logic eb, input logic [4:0] et, input logic [31:0] ev);
        rs2_addr = a;
        #1;
        checks++;
        assert ({rs2_busy, rs2_tag, rs2_value} === {eb, et, ev})
        else begin
            errors++;
            $error("FAIL %s: rs2 x%0d got busy=%b tag=%0d value=%h, expected busy=%b tag=%0d value=%h",
                   name, a, rs2_busy, rs2_tag, rs2_value, eb, et, ev);
        end
    endtask

    initial begin
        idle();
        rdy = 1'b1;
        rst = 1'b1;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        step();
        step();
        rst = 1'b0;
        rd1("reset_x5", 5'd5, 1'b0, 5'd0, 32'h0);
        rd2("reset_x0", 5'd0, 1'b0, 5'd0, 32'h0);

        // x0 ignores commits and renames
        commit(5'd0, 5'd0, 32'hDEAD);
        step();
        idle();
        rename(5'd0, 5'd3);
        step();
        idle();
        rd1("x0_after_writes", 5'd0, 1'b0, 5'd0, 32'h0);

        // Rename then matching commit with bypass
        rename(5'd5, 5'd3);
        step();
        idle();
        rd1("x5_renamed", 5'd5, 1'b1, 5'd3, 32'h0);
        commit(5'd5, 5'd3, 32'h1234);
        rd1("x5_bypass", 5'd5, 1'b0, 5'd0, 32'h1234);
        step();
        idle();
        rd1("x5_committed", 5'd5, 1'b0, 5'd0, 32'h1234);

        // Older commit must not clear a younger rename
        rename(5'd7, 5'd2);
        step();
        rename(5'd7, 5'd4);
        step();
        idle();
        rd2("x7_twice_renamed", 5'd7, 1'b1, 5'd4, 32'h0);
        commit(5'd7, 5'd2, 32'h11);
        rd2("x7_no_bypass_old_tag", 5'd7, 1'b1, 5'd4, 32'h0);
        step();
        idle();
        rd2("x7_old_commit", 5'd7, 1'b1, 5'd4, 32'h11);
        commit(5'd7, 5'd4, 32'h22);
        rd2("x7_bypass_young", 5'd7, 1'b0, 5'd0, 32'h22);
        step();
        idle();
        rd2("x7_young_commit", 5'd7, 1'b0, 5'd0, 32'h22);

        // Same-cycle commit and rename of one register
        commit(5'd9, 5'd6, 32'h55);
        rename(5'd9, 5'd8);
        rd1("x9_pre_rename_read", 5'd9, 1'b0, 5'd0, 32'h0);
        step();
        idle();
        rd1("x9_commit_and_rename", 5'd9, 1'b1, 5'd8, 32'h55);

        // Flush with commit and rename in the same cycle
        rename(5'd1, 5'd1);
        step();
        rename(5'd2, 5'd2);
        step();
        rename(5'd3, 5'd3);
        step();
        idle();
        rd1("x1_pending", 5'd1, 1'b1, 5'd1, 32'h0);
        rd2("x3_pending", 5'd3, 1'b1, 5'd3, 32'h0);
        flush = 1'b1;
        commit(5'd4, 5'd5, 32'h77);
        rename(5'd6, 5'd9);
        step();
        idle();
        rd1("flush_x1", 5'd1, 1'b0, 5'd0, 32'h0);
        rd2("flush_x2", 5'd2, 1'b0, 5'd0, 32'h0);
        rd1("flush_x3", 5'd3, 1'b0, 5'd0, 32'h0);
        rd2("flush_x4_value", 5'd4, 1'b0, 5'd0, 32'h77);
        step();
        rd1("flush_x6_no_rename", 5'd6, 1'b0, 5'd0, 32'h0);
        rd2("flush_x9", 5'd9, 1'b0, 5'd0, 32'h55);

        // rdy low holds all state
        step();
        rdy = 1'b0;
        commit(5'd10, 5'd1, 32'h99);
        rename(5'd11, 5'd5);
        step();
        idle();
        rdy = 1'b1;
        rd1("stall_x10", 5'd10, 1'b0, 5'd0, 32'h0);
        rd2("stall_x11", 5'd11, 1'b0, 5'd0, 32'h0);

        // Reset mid-run clears everything
        rename(5'd12, 5'd7);
        step();
        idle();
        rd1("x12_renamed", 5'd12, 1'b1, 5'd7, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd1("rst_x12", 5'd12, 1'b0, 5'd0, 32'h0);
        rd2("rst_x5", 5'd5, 1'b0, 5'd0, 32'h0);
        rd1("rst_x4", 5'd4, 1'b0, 5'd0, 32'h0);
        rd2("rst_x7", 5'd7, 1'b0, 5'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
